lut_cfg_loader: RTL and testbench
=================================

// Module: lut_cfg_loader
// PURPOSE
//  Upstream configuration stage for the 3-input LUT array: receives a serial config
//  bitstream, assembles one 8-bit truth-table word per LUT in a shadow buffer, and
//  commits all words at once. Holds LUT enable low while loading.
//  Sits between the config port and the LUT instances; drives their INIT and enable inputs.
// PARAMETERS
//  NUM_LUTS   4   number of 3-input LUTs configured (1..16)
//  INIT_W     8   truth-table bits per LUT (2**3); fixed, exported from package
// PORTS
//  clk            in   1               single clock, all logic rising-edge
//  rst            in   1               synchronous, active-high reset
//  cfg_start      in   1               pulse: begin a load (accepted in IDLE/DONE/ERR only)
//  cfg_abort      in   1               abandon current load, no commit
//  cfg_bit        in   1               serial config data
//  cfg_bit_valid  in   1               cfg_bit is valid this cycle
//  cfg_bit_ready  out  1               loader accepts a bit this cycle
//  cfg_busy       out  1               high in SHIFT (and PAR with parity)
//  cfg_done       out  1               1-cycle pulse on successful commit
//  cfg_err        out  1               sticky until next cfg_start or rst
//  lut_init       out  NUM_LUTS*INIT_W committed truth tables, LUT k at [k*8 +: 8]
//  lut_enable     out  1               enable to all LUTs
// BEHAVIOUR
//  - Reset: state IDLE; lut_init=0, lut_enable=0, cfg_busy=0, cfg_done=0, cfg_err=0,
//    cfg_bit_ready=0, has_cfg=0. Reset mid-load discards the shadow buffer.
//  - FSM: IDLE -start-> SHIFT; SHIFT -8 bits-> (PAR if parity else next word/COMMIT);
//    COMMIT -> DONE; DONE/ERR -start-> SHIFT; any state -abort-> IDLE.
//  - Transfer: bit accepted when cfg_bit_valid && cfg_bit_ready; ready=1 only in SHIFT/PAR.
//  - Order: word 0 first, MSB (bit 7) first within a word; word count NUM_LUTS.
//  - cfg_start is ignored in SHIFT/PAR. cfg_abort beats cfg_start in the same cycle.
//    cfg_abort beats a bit accepted in the same cycle.
//  - lut_enable drops the cycle after cfg_start is accepted and stays 0 while loading.
//  - COMMIT: lut_init <= shadow, has_cfg <= 1. Then, in DONE: cfg_done=1 for one cycle
//    and lut_enable=1. Last accepted bit -> cfg_done high exactly 2 cycles later.
//  - Abort: lut_init unchanged; lut_enable <= has_cfg. Error: same restore, cfg_err=1.
//  - Bit/word counters wrap at 8 / NUM_LUTS; no extra bits accepted after the last word.
// CONFIGURATION
//  CFG_PARITY_EN defined:
//   - An odd-parity bit follows each 8-bit word (state PAR).
//   - A mismatch -> ERR with no commit.
//  Undefined:
//   - There is no PAR state and no parity bit; 8*NUM_LUTS bits per load.
//   - cfg_err is never set and is tied 0.
// STRUCTURE
//  Package lut_cfg_pkg:
//   - state enum {IDLE,SHIFT,PAR,COMMIT,DONE,ERR}
//   - localparam LUT_INIT_W=8
//   - helper function odd_parity(logic [7:0])
//  Sub-module lut_cfg_shreg: 8-bit MSB-first shift register plus 3-bit bit counter.
//   - Outputs word_full and the assembled word.
//   - The parent handles word indexing and the shadow buffer.
// TESTING
//  1 rst, start, stream 0xE8,0x96,0x01,0xFE with no gaps
//    -> lut_init=0xFE0196E8, done 2 cycles after last bit, enable=1
//  2 Same stream with cfg_bit_valid toggling every other cycle
//    -> identical lut_init; busy spans the whole transfer
//  3 After test 1, start and abort after 12 bits
//    -> lut_init stays 0xFE0196E8, enable back to 1, no done pulse
//  4 rst asserted mid-load after 20 bits
//    -> all outputs 0, IDLE next cycle, a following full load works
//  5 cfg_start asserted during SHIFT and abort+start in same cycle
//    -> start ignored / abort wins, state IDLE
//  6 [CFG_PARITY_EN] word 0x96 with parity 0 (wrong)
//    -> cfg_err=1, no commit, enable=has_cfg; correct parity 1 -> normal commit

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration loader.
// Contents: loader FSM state enum, truth-table width, odd-parity helper.
package lut_cfg_pkg;

    // Truth-table bits per 3-input LUT (2**3)
    localparam int unsigned LUT_INIT_W = 8;
    localparam int unsigned BIT_CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PAR,
        COMMIT,
        DONE,
        ERR
    } state_t;

    // Bit that makes the word plus parity bit contain an odd number of ones
    function automatic logic odd_parity(input logic [LUT_INIT_W-1:0] w);
        return ~(^w);
    endfunction

endpackage

// File: rtl/lut_cfg_shreg.sv
// MSB-first serial-to-parallel assembler for one LUT truth-table word.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           restart the word (counter and history cleared)
//   shift_en      accept bit_in this cycle
//   bit_in        serial data
//   word_c        assembled word including the bit arriving this cycle
//   word_full_c   this shift completes the current 8-bit word
module lut_cfg_shreg
    import lut_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic                  bit_in,
    output logic [LUT_INIT_W-1:0] word_c,
    output logic                  word_full_c
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(LUT_INIT_W - 1);

    // Only the previous 7 bits need storage; the 8th is the incoming bit
    logic [LUT_INIT_W-2:0] sr_q;
    logic [BIT_CNT_W-1:0]  cnt_q;

    assign word_c      = {sr_q, bit_in};
    assign word_full_c = shift_en && (cnt_q == LAST_BIT);

    // History register and bit counter; counter wraps naturally at 8
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            sr_q  <= word_c[LUT_INIT_W-2:0];
            cnt_q <= cnt_q + BIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for the 3-input LUT array. Assembles one
// truth-table word per LUT in a shadow buffer and commits all words at once,
// holding the LUT enable low while a load is in progress.
// Build option: define CFG_PARITY_EN to expect an odd-parity bit after each
// word; a mismatch ends the load in ERR without commit.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_start       begin a load (IDLE/DONE/ERR only)
//   cfg_abort       abandon the load without commit (wins over everything)
//   cfg_bit         serial data, word 0 first, MSB first
//   cfg_bit_valid   cfg_bit valid this cycle
//   cfg_bit_ready   loader accepts a bit this cycle
//   cfg_busy        load in progress
//   cfg_done        one-cycle pulse after a successful commit
//   cfg_err         sticky parity error flag
//   lut_init        committed truth tables, LUT k at [k*8 +: 8]
//   lut_enable      enable to all LUTs
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int unsigned NUM_LUTS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic                           cfg_abort,
    input  logic                           cfg_bit,
    input  logic                           cfg_bit_valid,
    output logic                           cfg_bit_ready,
    output logic                           cfg_busy,
    output logic                           cfg_done,
    output logic                           cfg_err,
    output logic [NUM_LUTS*LUT_INIT_W-1:0] lut_init,
    output logic                           lut_enable
);

    localparam int unsigned CFG_W = NUM_LUTS * LUT_INIT_W;
    localparam int unsigned IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [CFG_W-1:0]   shadow_q;
    logic               has_cfg_q;

    logic               accept;
    logic               last_word;
    logic               start_ok;
    logic               shift_en;
    logic               shreg_clr;
    logic               wr_word;
    logic               commit;
    logic               enable_n;
    logic               done_n;
    logic               err_n;
    logic [LUT_INIT_W-1:0] word_c;
    logic               word_full_c;

    lut_cfg_shreg u_shreg (
        .clk         (clk),
        .rst         (rst),
        .clr         (shreg_clr),
        .shift_en    (shift_en),
        .bit_in      (cfg_bit),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        enable_n  = lut_enable;
        done_n    = 1'b0;
        err_n     = cfg_err;
        commit    = 1'b0;
        shift_en  = 1'b0;
        shreg_clr = 1'b0;
        wr_word   = 1'b0;
        start_ok  = 1'b0;
        accept    = cfg_bit_valid && cfg_bit_ready;
        last_word = (idx_q == LAST_IDX);

        case (state_q)
            IDLE, DONE, ERR: begin
                start_ok = cfg_start;
            end
            SHIFT: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (word_full_c) begin
                        wr_word = 1'b1;
`ifdef CFG_PARITY_EN
                        state_n = PAR;
`else
                        if (last_word) begin
                            state_n = COMMIT;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx_q + IDX_W'(1);
                        end
`endif
                    end
                end
            end
            PAR: begin
`ifdef CFG_PARITY_EN
                // The word just completed already sits in the shadow slot
                if (accept) begin
                    if (cfg_bit != odd_parity(shadow_q[idx_q*LUT_INIT_W +: LUT_INIT_W])) begin
                        state_n  = ERR;
                        idx_n    = '0;
                        err_n    = 1'b1;
                        enable_n = has_cfg_q;
                    end else if (last_word) begin
                        state_n = COMMIT;
                        idx_n   = '0;
                    end else begin
                        state_n = SHIFT;
                        idx_n   = idx_q + IDX_W'(1);
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            COMMIT: begin
                commit   = 1'b1;
                state_n  = DONE;
                done_n   = 1'b1;
                enable_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start_ok) begin
            state_n   = SHIFT;
            idx_n     = '0;
            enable_n  = 1'b0;
            err_n     = 1'b0;
            shreg_clr = 1'b1;
        end

        // Abort overrides start, bit acceptance, commit and error entry
        if (cfg_abort) begin
            state_n   = IDLE;
            idx_n     = '0;
            enable_n  = has_cfg_q;
            done_n    = 1'b0;
            err_n     = cfg_err;
            commit    = 1'b0;
            shift_en  = 1'b0;
            wr_word   = 1'b0;
            shreg_clr = 1'b1;
        end
    end

    // State, shadow buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_q      <= '0;
            has_cfg_q     <= 1'b0;
            lut_init      <= '0;
            lut_enable    <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_err       <= 1'b0;
            cfg_busy      <= 1'b0;
            cfg_bit_ready <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            if (wr_word) begin
                shadow_q[idx_q*LUT_INIT_W +: LUT_INIT_W] <= word_c;
            end
            if (commit) begin
                lut_init  <= shadow_q;
                has_cfg_q <= 1'b1;
            end
            lut_enable    <= enable_n;
            cfg_done      <= done_n;
            cfg_err       <= err_n;
            cfg_busy      <= (state_n == SHIFT) || (state_n == PAR);
            cfg_bit_ready <= (state_n == SHIFT) || (state_n == PAR);
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader (NUM_LUTS=4): vector table of complete
// loads plus hand-written reset, start/abort and parity sequences.
module tb_lut_cfg_loader;

    localparam int unsigned NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic          cfg_abort;
    logic          cfg_bit;
    logic          cfg_bit_valid;
    logic          cfg_bit_ready;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [NL*8-1:0] lut_init;
    logic          lut_enable;

    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_gaps = 0;
    logic mon_busy = 1'b0;

    typedef struct {
        logic [31:0] stream;
        int          gap;
        int          abort_at;
        int          mid_start_at;
        logic [31:0] exp_init;
        logic        exp_en;
    } vec_t;

    vec_t vecs[6];

    lut_cfg_loader #(.NUM_LUTS(NL)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_bit       (cfg_bit),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit_ready (cfg_bit_ready),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .lut_init      (lut_init),
        .lut_enable    (lut_enable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_busy && !cfg_busy) busy_gaps++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        cfg_bit       = b;
        cfg_bit_valid = 1'b1;
        while (!cfg_bit_ready && n < 20) begin
            tick();
            n++;
        end
        chk("bit_ready", 32'(cfg_bit_ready), 32'd1);
        tick();
        cfg_bit_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        logic  q[$];
        logic [7:0] wd;
        logic  aborted;
        logic  saw_done;
        q = {};
        for (int w = 0; w < int'(NL); w++) begin
            wd = v.stream[w*8 +: 8];
            for (int b = 7; b >= 0; b--) q.push_back(wd[b]);
`ifdef CFG_PARITY_EN
            q.push_back(~(^wd));
`endif
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("enable_low", 32'(lut_enable), 32'd0);
        chk("busy_start", 32'(cfg_busy), 32'd1);
        busy_gaps = 0;
        mon_busy  = 1'b1;
        aborted   = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == v.abort_at) begin
                mon_busy  = 1'b0;
                cfg_abort = 1'b1;
                tick();
                cfg_abort = 1'b0;
                aborted   = 1'b1;
                break;
            end
            if (i == v.mid_start_at) begin
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
            end
            send_bit(q[i]);
            if (i == q.size() - 1) mon_busy = 1'b0;
            else repeat (v.gap) tick();
        end
        chk("busy_span", 32'(busy_gaps), 32'd0);
        if (aborted) begin
            chk("abort_init", lut_init, v.exp_init);
            chk("abort_enable", 32'(lut_enable), 32'(v.exp_en));
            chk("abort_busy", 32'(cfg_busy), 32'd0);
            saw_done = 1'b0;
            repeat (4) begin
                tick();
                if (cfg_done) saw_done = 1'b1;
            end
            chk("abort_no_done", 32'(saw_done), 32'd0);
        end else begin
            chk("done_early", 32'(cfg_done), 32'd0);
            tick();
            chk("done_pulse", 32'(cfg_done), 32'd1);
            chk("lut_init", lut_init, v.exp_init);
            chk("lut_enable", 32'(lut_enable), 32'(v.exp_en));
            tick();
            chk("done_width", 32'(cfg_done), 32'd0);
        end
        chk("err_clear", 32'(cfg_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        cfg_bit       = 1'b0;
        cfg_bit_valid = 1'b0;

        vecs[0] = '{32'hFE0196E8, 0, -1, -1, 32'hFE0196E8, 1'b1};
        vecs[1] = '{32'hFE0196E8, 1, -1, -1, 32'hFE0196E8, 1'b1};
        vecs[2] = '{32'h12345678, 0, 12, -1, 32'hFE0196E8, 1'b1};
        vecs[3] = '{32'h0F0F3C3C, 0, -1,  5, 32'h0F0F3C3C, 1'b1};
        vecs[4] = '{32'hA5A5A5A5, 0, -1, -1, 32'hA5A5A5A5, 1'b1};
        vecs[5] = '{32'hFE0196E8, 2, -1, -1, 32'hFE0196E8, 1'b1};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_init", lut_init, 32'h0);
        chk("rst_enable", 32'(lut_enable), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_ready", 32'(cfg_bit_ready), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);

        foreach (vecs[k]) run_load(vecs[k]);

        // Reset in the middle of a load
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_init", lut_init, 32'h0);
        chk("midrst_enable", 32'(lut_enable), 32'd0);
        chk("midrst_busy", 32'(cfg_busy), 32'd0);
        chk("midrst_ready", 32'(cfg_bit_ready), 32'd0);
        chk("midrst_done", 32'(cfg_done), 32'd0);
        chk("midrst_err", 32'(cfg_err), 32'd0);
        run_load(vecs[0]);

        // Abort and start together from DONE: abort wins
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        chk("abst_done_busy", 32'(cfg_busy), 32'd0);
        chk("abst_done_ready", 32'(cfg_bit_ready), 32'd0);
        chk("abst_done_enable", 32'(lut_enable), 32'd1);
        tick();
        chk("abst_done_idle", 32'(cfg_busy), 32'd0);

        // Abort and start together during SHIFT
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        chk("abst_shift_busy", 32'(cfg_busy), 32'd0);
        chk("abst_shift_ready", 32'(cfg_bit_ready), 32'd0);
        chk("abst_shift_enable", 32'(lut_enable), 32'd1);
        chk("abst_shift_init", lut_init, 32'hFE0196E8);
        tick();
        chk("abst_shift_idle", 32'(cfg_busy), 32'd0);

`ifdef CFG_PARITY_EN
        // Wrong parity on the first word ends in ERR without commit
        begin
            logic [7:0] wd;
            wd = 8'h96;
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            for (int b = 7; b >= 0; b--) send_bit(wd[b]);
            send_bit(1'b0);
            chk("par_err", 32'(cfg_err), 32'd1);
            chk("par_enable", 32'(lut_enable), 32'd1);
            chk("par_busy", 32'(cfg_busy), 32'd0);
            chk("par_init", lut_init, 32'hFE0196E8);
            tick();
            chk("par_err_sticky", 32'(cfg_err), 32'd1);
            run_load('{32'h96969696, 0, -1, -1, 32'h96969696, 1'b1});
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
